// File: rtl/branch_eval_unit_pkg.sv
// Shared core package: comparison encodings, control state and the
// captured jump/branch operation bundle.
package branch_eval_unit_pkg;

    localparam logic [2:0] CMP_NONE   = 3'b000;
    localparam logic [2:0] CMP_EQ     = 3'b001;
    localparam logic [2:0] CMP_NE     = 3'b010;
    localparam logic [2:0] CMP_LT     = 3'b011;
    localparam logic [2:0] CMP_LTU    = 3'b100;
    localparam logic [2:0] CMP_GE     = 3'b101;
    localparam logic [2:0] CMP_GEU    = 3'b110;
    localparam logic [2:0] CMP_ALWAYS = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic        jalr;
        logic [2:0]  ctrl;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } bru_op_t;

endpackage

// File: rtl/branch_eval_unit_arith.sv
// Combinational datapath blocks for the branch unit: a 32-bit
// condition comparator and a 32-bit wrapping adder.
import branch_eval_unit_pkg::*;

module cmp_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ctrl,
    output logic        c
);

    always_comb begin
        c = 1'b0;
        case (ctrl)
            CMP_NONE:   c = 1'b0;
            CMP_EQ:     c = (a == b);
            CMP_NE:     c = (a != b);
            CMP_LT:     c = ($signed(a) < $signed(b));
            CMP_LTU:    c = (a < b);
            CMP_GE:     c = ($signed(a) >= $signed(b));
            CMP_GEU:    c = (a >= b);
            CMP_ALWAYS: c = 1'b1;
            default:    c = 1'b0;
        endcase
    end

endmodule

module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    assign c = a + b;

endmodule

// File: rtl/branch_eval_unit.sv
// Two-cycle jump/branch evaluation: capture on issue, results
// (condition, target, link) valid for one cycle after.
import branch_eval_unit_pkg::*;

module branch_eval_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        JALR,
    input  logic [2:0]  cmp_ctrl,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] PC,
    output logic [31:0] PC_jump,
    output logic [31:0] PC_wb,
    output logic        cmp_res,
    output logic        valid
);

    bru_state_e  state_q, state_d;
    bru_op_t     op_q, op_d;
    logic [31:0] base;
    logic [31:0] tgt_sum;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = BUSY;
                    op_d    = '{jalr: JALR, ctrl: cmp_ctrl,
                                rs1: rs1_data, rs2: rs2_data,
                                imm: imm, pc: PC};
                end
            end
            BUSY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign base = op_q.jalr ? op_q.rs1 : op_q.pc;

    cmp_32 u_cmp (
        .a    (op_q.rs1),
        .b    (op_q.rs2),
        .ctrl (op_q.ctrl),
        .c    (cmp_res)
    );

    add_32 u_add_tgt (
        .a (base),
        .b (op_q.imm),
        .c (tgt_sum)
    );

    add_32 u_add_link (
        .a (op_q.pc),
        .b (32'd4),
        .c (PC_wb)
    );

    // JALR targets are halfword-aligned by clearing the sum's LSB
    assign PC_jump = {tgt_sum[31:1], tgt_sum[0] & ~op_q.jalr};
    assign valid   = (state_q == BUSY);

endmodule

// File: tb/tb_branch_eval_unit.sv
// Scoreboard bench for branch_eval_unit: driver predicts each cycle's
// outputs from a behavioural model, monitor compares after each edge.
module tb_branch_eval_unit;
    import branch_eval_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, EN, JALR;
    logic [2:0]  cmp_ctrl;
    logic [31:0] rs1_data, rs2_data, imm, PC;
    logic [31:0] PC_jump, PC_wb;
    logic        cmp_res, valid;

    typedef struct {
        bit        v;
        bit        c;
        bit [31:0] j;
        bit [31:0] w;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit        m_busy = 1'b0;
    bit        m_jalr = 1'b0;
    bit [2:0]  m_ctrl = 3'd0;
    bit [31:0] m_rs1 = 0, m_rs2 = 0, m_imm = 0, m_pc = 0;

    branch_eval_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EN       (EN),
        .JALR     (JALR),
        .cmp_ctrl (cmp_ctrl),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .imm      (imm),
        .PC       (PC),
        .PC_jump  (PC_jump),
        .PC_wb    (PC_wb),
        .cmp_res  (cmp_res),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    function automatic bit ref_cmp(bit [2:0] k, bit [31:0] a, bit [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (k)
            3'd0:    return 1'b0;
            3'd1:    return ua == ub;
            3'd2:    return ua != ub;
            3'd3:    return sa < sb;
            3'd4:    return ua < ub;
            3'd5:    return sa >= sb;
            3'd6:    return ua >= ub;
            default: return 1'b1;
        endcase
    endfunction

    // One clock of stimulus; predicts the outputs seen after the next edge
    task automatic step(input bit rn, input bit en, input bit jr,
                        input bit [2:0] k, input bit [31:0] a,
                        input bit [31:0] b, input bit [31:0] im,
                        input bit [31:0] p);
        exp_t      e;
        bit [31:0] t;
        @(negedge clk);
        rst_n = rn; EN = en; JALR = jr; cmp_ctrl = k;
        rs1_data = a; rs2_data = b; imm = im; PC = p;
        if (!rn) begin
            m_busy = 0; m_jalr = 0; m_ctrl = 0;
            m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
        end else if (m_busy) begin
            m_busy = 0;
        end else if (en) begin
            m_busy = 1; m_jalr = jr; m_ctrl = k;
            m_rs1 = a; m_rs2 = b; m_imm = im; m_pc = p;
        end
        t = (m_jalr ? m_rs1 : m_pc) + m_imm;
        if (m_jalr) t = t & 32'hFFFF_FFFE;
        e.v = m_busy;
        e.c = ref_cmp(m_ctrl, m_rs1, m_rs2);
        e.j = t;
        e.w = m_pc + 32'd4;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid", {31'd0, valid}, {31'd0, e.v});
                chk("cmp_res", {31'd0, cmp_res}, {31'd0, e.c});
                chk("PC_jump", PC_jump, e.j);
                chk("PC_wb", PC_wb, e.w);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit [2:0]  ks [6];
        bit [31:0] a, b;
        rst_n = 0; EN = 0; JALR = 0; cmp_ctrl = 0;
        rs1_data = 0; rs2_data = 0; imm = 0; PC = 0;
        ks = '{CMP_LT, CMP_LTU, CMP_GE, CMP_GEU, CMP_EQ, CMP_NE};

        step(0, 1, 1, 3'd7, 32'h1234, 32'h5, 32'h9, 32'h100);
        step(0, 0, 0, 3'd0, 0, 0, 0, 0);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);
        step(1, 0, 1, 3'd7, 32'hFF, 32'h1, 32'h7, 32'h33);

        foreach (ks[i]) begin
            step(1, 1, 0, ks[i], 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h200);
            step(1, 0, 0, 3'd0, 0, 0, 0, 0);
        end

        step(1, 1, 0, CMP_ALWAYS, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h1000);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);
        step(1, 1, 1, CMP_ALWAYS, 32'h2001, 32'h0, 32'h4, 32'h3000);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);
        step(1, 1, 0, CMP_ALWAYS, 32'h0, 32'h0, 32'h8, 32'hFFFF_FFFC);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++)
            step(1, 1, i[0], 3'(i + 1), 32'(i * 17), 32'(i * 3),
                 32'(i * 64 + 1), 32'h4000 + 32'(i * 4));
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);
        step(1, 1, 0, CMP_GEU, 32'h9, 32'h2, 32'h40, 32'h5000);
        step(0, 1, 1, CMP_EQ, 32'h7, 32'h7, 32'h8, 32'h6000);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0,
                 1'($urandom), 3'($urandom), a, b, $urandom, $urandom);
        end
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
